dot_product_feeder: RTL

DOT_PRODUCT_FEEDER -- requirements
Module: dot_product_feeder

---
 rtl/dot_product_feeder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dot_product_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_feeder
// Description : Pops one operand word from each of two source FIFOs and
//               registers the pair onto mem1_input/mem2_input. It holds the
//               pair for SETTLE_CYCLES, pulses start_processing for one cycle,
//               waits for processing_done, then presents the result on a
//               valid/ready handshake.
//
// Build option: FEEDER_TIMEOUT_EN
//               When defined, a watchdog bounds WAIT_DONE to TIMEOUT_CYCLES
//               and sets the sticky err_timeout flag. When undefined,
//               err_timeout is tied 0.
//
// Ports       : clk, rst_n            clock and async active-low reset
//               enable                allows fetching a new vector pair
//               fifo{1,2}_empty/rd_en/dout  source FIFO interfaces
//               mem{1,2}_input        registered operands to the compute stage
//               start_processing      one-cycle capture strobe
//               processing_done       completion strobe from the compute stage
//               dot_product_result    result from the compute stage
//               res_valid/res_ready/res_data  result handshake
//               vec_count             number of accepted results (wraps)
//               busy                  FSM is not in IDLE
//               err_timeout           sticky watchdog error
//
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_feeder #(
  parameter int DATA_WIDTH     = 32,
  parameter int RESULT_WIDTH   = 16,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    fifo1_empty,
  input  logic                    fifo2_empty,
  output logic                    fifo1_rd_en,
  output logic                    fifo2_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo1_dout,
  input  logic [DATA_WIDTH-1:0]   fifo2_dout,
  output logic [DATA_WIDTH-1:0]   mem1_input,
  output logic [DATA_WIDTH-1:0]   mem2_input,
  output logic                    start_processing,
  input  logic                    processing_done,
  input  logic [RESULT_WIDTH-1:0] dot_product_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [RESULT_WIDTH-1:0] res_data,
  output logic [15:0]             vec_count,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_POP       = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_HOLD      = 3'd3;
  localparam logic [2:0] S_START     = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_OUTPUT    = 3'd6;

  // Last value of the settle counter before leaving HOLD.
  localparam logic [15:0] C_SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? 16'(SETTLE_CYCLES - 1) : 16'd0;

  logic [2:0]              r_state;
  logic [15:0]             r_settle_cnt;
  logic [DATA_WIDTH-1:0]   r_mem1;
  logic [DATA_WIDTH-1:0]   r_mem2;
  logic                    r_res_valid;
  logic [RESULT_WIDTH-1:0] r_res_data;
  logic [15:0]             r_vec_count;
  logic                    w_fetch_ok;

`ifdef FEEDER_TIMEOUT_EN
  localparam logic [15:0] C_TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
  logic [15:0] r_tmo_cnt;
  logic        r_err_timeout;
`endif

  assign w_fetch_ok = enable && !fifo1_empty && !fifo2_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= 16'd0;
      r_mem1       <= '0;
      r_mem2       <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_vec_count  <= 16'd0;
`ifdef FEEDER_TIMEOUT_EN
      r_tmo_cnt     <= 16'd0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fetch_ok) r_state <= S_POP;
        end
        S_POP: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          // FIFO data is valid the cycle after the pop strobe.
          r_mem1       <= fifo1_dout;
          r_mem2       <= fifo2_dout;
          r_settle_cnt <= 16'd0;
          r_state      <= (SETTLE_CYCLES == 0) ? S_START : S_HOLD;
        end
        S_HOLD: begin
          if (r_settle_cnt == C_SETTLE_LAST) begin
            r_state <= S_START;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        S_START: begin
          r_state <= S_WAIT_DONE;
`ifdef FEEDER_TIMEOUT_EN
          r_tmo_cnt <= 16'd0;
`endif
        end
        S_WAIT_DONE: begin
          if (processing_done) begin
            r_res_data  <= dot_product_result;
            r_res_valid <= 1'b1;
            r_state     <= S_OUTPUT;
          end
`ifdef FEEDER_TIMEOUT_EN
          // Abandon the vector: no result, count untouched.
          else if (r_tmo_cnt == C_TMO_LAST) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        S_OUTPUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_vec_count <= r_vec_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode directly from state so they drop the moment reset asserts.
  assign fifo1_rd_en      = (r_state == S_POP);
  assign fifo2_rd_en      = (r_state == S_POP);
  assign start_processing = (r_state == S_START);
  assign busy             = (r_state != S_IDLE);
  assign mem1_input       = r_mem1;
  assign mem2_input       = r_mem2;
  assign res_valid        = r_res_valid;
  assign res_data         = r_res_data;
  assign vec_count        = r_vec_count;

`ifdef FEEDER_TIMEOUT_EN
  assign err_timeout = r_err_timeout;
`else
  // Watchdog not built; keep the parameter referenced.
  logic w_unused_timeout;
  assign w_unused_timeout = |32'(TIMEOUT_CYCLES);
  assign err_timeout      = 1'b0;
`endif

endmodule
`default_nettype wire
